// File: rtl/fft_8192_radix2_core.sv
// fft_8192_radix2_core: 8192-point in-place radix-2 DIT FFT that loads its own test frame and streams float32 bins.
// Defining FFT_DC_PATTERN_EN loads a DC frame instead of the default impulse.
module fft_8192_radix2_core (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        dout_valid,
   output logic [63:0] dout,
   output logic        dout_finish
);
   localparam int N  = 8192;
   localparam int DW = 32;
   localparam int TW = 18;

   typedef enum logic [2:0] {IDLE, LOAD, CALC, OUT, DONE} state_t;

   function automatic logic [12:0] bitrev13(input logic [12:0] v);
      logic [12:0] r;
      for (int i = 0; i < 13; i++) r[i] = v[12-i];
      return r;
   endfunction

   function automatic int rnd(input real v);
      return (v < 0.0) ? -$rtoi(0.5 - v) : $rtoi(v + 0.5);
   endfunction

   // {cos, -sin} in Q2.16, so the ROM holds W itself
   function automatic logic [2*TW-1:0] tw_entry(input int k);
      real ang;
      ang = 6.283185307179586 * real'(k) / 8192.0;
      return {TW'(rnd($cos(ang) * 65536.0)), TW'(-rnd($sin(ang) * 65536.0))};
   endfunction

   function automatic logic signed [DW-1:0] qmul(input logic signed [DW-1:0] x, input logic signed [TW-1:0] w);
      logic signed [DW+TW-1:0] p;
      p = (DW+TW)'(x) * (DW+TW)'(w) + (DW+TW)'(32768);
      return p[DW+15:16];
   endfunction

   function automatic logic [31:0] f32(input logic signed [DW-1:0] v);
      logic [31:0] m;
      logic [31:0] n;
      logic [4:0]  p;
      m = v[31] ? -v : v;
      p = 5'd0;
      for (int i = 0; i < 32; i++) if (m[i]) p = 5'(i);
      n = m << (5'd31 - p);
      return (v == 0) ? 32'd0 : {v[31], 8'd127 + 8'(p), n[30:8]};
   endfunction

   state_t r_state, w_next;
   logic [12:0]       r_cnt;
   logic [3:0]        r_s;
   logic [1:0]        r_ph;
   logic [2*DW-1:0]   r_ram [N];
   logic [2*DW-1:0]   r_rd;
   logic [2*DW-1:0]   r_xa;
   logic [2*TW-1:0]   r_w;
   logic              r_rd_v;

   logic [2*TW-1:0]   w_rom [4096];
   logic [12:0]       w_b, w_mask, w_a, w_c, w_addr;
   logic [11:0]       w_k;
   logic              w_we, w_last;
   logic [2*DW-1:0]   w_wdata;
   logic [DW-1:0]     w_src;
   logic signed [DW-1:0] w_xr, w_xi, w_ar, w_ai, w_tr, w_ti;
   logic signed [TW-1:0] w_wr, w_wi;

   for (genvar i = 0; i < 4096; i++) begin : g_rom
      localparam logic [2*TW-1:0] ENTRY = tw_entry(i);
      assign w_rom[i] = ENTRY;
   end

`ifdef FFT_DC_PATTERN_EN
   assign w_src = 32'd1;
`else
   assign w_src = {31'd0, r_cnt == 13'd0};
`endif

   // butterfly b of stage s pairs a and c = a + 2^s; bit s of a is always 0
   assign w_b    = {1'b0, r_cnt[11:0]};
   assign w_mask = (13'd1 << r_s) - 13'd1;
   assign w_a    = ((w_b & ~w_mask) << 1) | (w_b & w_mask);
   assign w_c    = w_a | (w_mask + 13'd1);
   assign w_k    = 12'((w_b & w_mask) << (4'd12 - r_s));
   assign w_last = r_cnt == 13'd8191;

   assign {w_xr, w_xi} = r_rd;
   assign {w_ar, w_ai} = r_xa;
   assign {w_wr, w_wi} = r_w;
   assign w_tr = qmul(w_xr, w_wr) - qmul(w_xi, w_wi);
   assign w_ti = qmul(w_xr, w_wi) + qmul(w_xi, w_wr);

   always_comb begin
      w_addr  = r_cnt;
      w_we    = 1'b0;
      w_wdata = '0;
      if (r_state == LOAD) begin
         w_addr  = bitrev13(r_cnt);
         w_we    = 1'b1;
         w_wdata = {w_src, 32'd0};
      end else if (r_state == CALC) begin
         w_addr  = r_ph[0] ? w_c : w_a;
         w_we    = r_ph[1];
         w_wdata = r_ph[0] ? {w_ar - w_tr, w_ai - w_ti} : {w_ar + w_tr, w_ai + w_ti};
      end
   end

   // r_rd keeps x[c] through both write phases because it only loads on reads
   always_ff @(posedge clk) begin
      if (w_we) r_ram[w_addr] <= w_wdata;
      else r_rd <= r_ram[w_addr];
      if (r_state == CALC && r_ph == 2'd1) r_xa <= r_rd;
      r_w <= w_rom[w_k];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = en ? LOAD : IDLE;
         LOAD:    w_next = w_last ? CALC : LOAD;
         CALC:    w_next = (r_s == 4'd12 && &r_cnt[11:0] && r_ph == 2'd3) ? OUT : CALC;
         OUT:     w_next = w_last ? DONE : OUT;
         default: w_next = r_state;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_s   <= '0;
         r_ph  <= '0;
      end else if (r_state == LOAD || r_state == OUT) begin
         r_cnt <= r_cnt + 13'd1;
      end else if (r_state == CALC) begin
         r_ph <= r_ph + 2'd1;
         if (r_ph == 2'd3) begin
            r_cnt <= {1'b0, r_cnt[11:0] + 12'd1};
            if (&r_cnt[11:0]) r_s <= r_s + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_v      <= 1'b0;
         dout_valid  <= 1'b0;
         dout        <= '0;
         dout_finish <= 1'b0;
      end else begin
         r_rd_v      <= r_state == OUT;
         dout_valid  <= r_rd_v;
         dout        <= r_rd_v ? {f32(r_rd[63:32]), f32(r_rd[31:0])} : 64'd0;
         dout_finish <= r_state == DONE && !r_rd_v;
      end
   end
endmodule

// File: tb/tb_fft_8192_radix2_core.sv
// tb_fft_8192_radix2_core: scoreboard bench for the self-loading 8192-point FFT core.
// Expected bins follow the build: impulse by default, DC when FFT_DC_PATTERN_EN is defined.
module tb_fft_8192_radix2_core;
   localparam int N   = 8192;
   localparam int LAT = 221186;
`ifdef FFT_DC_PATTERN_EN
   localparam logic [63:0] FIRST = 64'h46000000_00000000;
   localparam logic [63:0] REST  = 64'h00000000_00000000;
`else
   localparam logic [63:0] FIRST = 64'h3F800000_00000000;
   localparam logic [63:0] REST  = 64'h3F800000_00000000;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b1;
   logic        dout_valid, dout_finish;
   logic [63:0] dout;
   logic [63:0] exp_q [$];
   logic [63:0] mon_e;
   logic        bad;
   int n_vec = 0, n_err = 0, n_seen = 0, cyc = 0, t0 = 0;

   fft_8192_radix2_core dut (
      .clk(clk), .rst(rst), .en(en),
      .dout_valid(dout_valid), .dout(dout), .dout_finish(dout_finish)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   // monitor: each valid pops one expected bin and must land on its exact cycle
   always @(negedge clk) begin
      if (!rst && dout_valid) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_valid: dout=%h at cycle %0d with no bin outstanding", dout, cyc - t0);
         end else begin
            mon_e = exp_q.pop_front();
            chk($sformatf("bin%0d", n_seen), dout, mon_e);
            chk($sformatf("bin%0d_cycle", n_seen), 64'(cyc - t0), 64'(LAT + n_seen));
            n_seen++;
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_valid", 64'(dout_valid), 64'd0);
      chk("rst_dout", dout, 64'd0);
      chk("rst_finish", 64'(dout_finish), 64'd0);

      en  = 1'b0;
      rst = 1'b0;
      bad = 1'b0;
      repeat (1000) begin
         @(negedge clk);
         if (dout_valid || dout_finish || dout !== 64'd0) bad = 1'b1;
      end
      chk("idle_hold", 64'(bad), 64'd0);

      en = 1'b1;
      repeat (8300) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("calc_rst_valid", 64'(dout_valid), 64'd0);
      chk("calc_rst_dout", dout, 64'd0);
      chk("calc_rst_finish", 64'(dout_finish), 64'd0);
      repeat (2) @(negedge clk);
      chk("rst_en_dominates", 64'(dout_valid | dout_finish), 64'd0);

      rst = 1'b0;
      t0  = cyc + 1;
      for (int k = 0; k < N; k++) exp_q.push_back(k == 0 ? FIRST : REST);
      for (int i = 0; i < LAT + N + 50 && !dout_finish; i++) @(negedge clk);
      chk("finish_cycle", 64'(cyc - t0), 64'(LAT + N));
      chk("bins_outstanding", 64'(exp_q.size()), 64'd0);
      chk("bins_seen", 64'(n_seen), 64'(N));

      bad = 1'b0;
      repeat (10000) begin
         @(negedge clk);
         if (dout_valid || !dout_finish) bad = 1'b1;
      end
      chk("done_hold", 64'(bad), 64'd0);

      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_clear_finish", 64'(dout_finish), 64'd0);
      chk("async_clear_dout", dout, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fft_8192_radix2_core.md
# fft_8192_radix2_core

Self-contained 8192-point complex FFT: generates an internal test frame, transforms it in place with a radix-2 decimation-in-time engine, and streams the 8192 natural-order bins out as IEEE-754 single-precision complex words. Sits at the top of the FFT verification build, where a bench only enables it and captures `dout`. One frame per reset.

## Interface
- `N` — 8192 — transform length (fixed).
- `DW` — 32 — signed internal width per real/imag component.
- `TW` — 18 — signed twiddle width, Q2.16 (1.0 = 65536).
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  start request; sampled only in IDLE.
- `dout_valid`  out  1  `dout` holds a bin this cycle.
- `dout`  out  64  `{re_f32[63:32], im_f32[31:0]}` of bin k.
- `dout_finish`  out  1  frame complete; high in DONE.

## Operation
- States: IDLE → LOAD → CALC → OUT → DONE. DONE is terminal until `rst`.
- Memory: 8192 × 64 RAM (`re`, `im` each `DW` signed), one access per cycle.
- IDLE: on a clock edge with `en`=1, go to LOAD.
- LOAD, 8192 cycles, n = 0..8191: write x[n] to address bitrev13(n).
  - Default source: impulse, x[0] = 1+0j, all others 0.
  - The value 1.0 is integer LSB 1.
- CALC: stages s = 0..12, butterflies b = 0..4095 in each stage.
  - half = 2^s; a = (b>>s)·2·half + (b & (half−1)); c = a + half.
  - Twiddle index k = (b & (half−1)) << (12−s).
  - Twiddle W = cos(2πk/8192) − j·sin(2πk/8192), from a 4096-entry ROM.
  - ROM entries are rounded to nearest, in Q2.16.
  - Butterfly: t = W·x[c]; x[a] ← x[a]+t; x[c] ← x[a]−t.
  - Each real product is DW×TW, then +2^15, then arithmetic >>16.
  - All adds and subtracts wrap modulo 2^32; no saturation.
- Each butterfly takes exactly 4 cycles: read a, read c, write a, write c.
- OUT: read addresses 0..8191 in order and convert each component to float32.
  - 0 maps to 0x00000000.
  - Otherwise: sign/magnitude, normalize, mantissa truncated toward zero, exponent = 127 + msb position.
- `en` changes after leaving IDLE are ignored.

## Timing
- Reset values: `dout_valid`=0, `dout`=0, `dout_finish`=0, state IDLE, all counters 0.
- Cycle 0 is the edge on which IDLE→LOAD occurs.
- LOAD occupies cycles 1..8192.
- CALC occupies 13·4096·4 = 212992 cycles.
- OUT issues one read per cycle. Each bin's `dout_valid` and `dout` are registered 2 cycles after its read is issued (RAM read, then convert).
- First `dout_valid` occurs 221186 cycles after cycle 0.
- `dout_valid` is then high for exactly 8192 consecutive cycles.
- Bin k appears on the k-th valid cycle.
- `dout_finish` rises the cycle after the last valid and stays high; `dout_valid` stays 0 thereafter.
- `rst` asserted mid-frame: immediately returns to IDLE and clears all outputs. RAM contents need not be cleared; the next LOAD overwrites every address.
- `rst` and `en` high together: reset dominates. The start is taken on the first edge after release if `en` is still 1.

## Configuration
- `FFT_DC_PATTERN_EN` defined: LOAD source is DC, x[n] = 1+0j for all n.
  - Exact result: X[0] = 8192.0 (`dout` = 0x46000000_00000000); all other bins 0x00000000_00000000.
- Not defined: impulse source.
  - Exact result: every bin = 1.0+0j (`dout` = 0x3F800000_00000000).

## Test plan
- Impulse build: `rst` high, `en`=1, release `rst` → exactly 8192 valid words, every one 0x3F800000_00000000; `dout_finish` high one cycle after the last.
- DC build, same stimulus → first word 0x46000000_00000000; the remaining 8191 words all zero.
- Latency: count edges from the start edge → first `dout_valid` at 221186; valids contiguous; no valid after the 8192nd.
- `en` held 0 after reset for 1000 cycles → stays in IDLE, all outputs 0; raising `en` then starts a normal frame.
- `rst` pulsed during CALC, then a restart → outputs cleared asynchronously; the restarted frame is bit-identical to a clean run.
- DONE persistence: hold `en`=1 for 10000 cycles after finish → no new valids, `dout_finish` stays 1 until `rst`.
